// File: rtl/branch_fetch_ctrl.sv
// Fetch-side PC sequencer: honours the single MIPS delay slot and parks a redirect target when the delay-slot fetch is still outstanding.
// Optional branch/taken counters are built only when BRANCH_STATS_EN is defined.
module branch_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_is_branch,
  input  logic        id_is_jump,
  input  logic        action,
  input  logic [31:0] id_target,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        redirect_pending,
  output logic [31:0] branch_count,
  output logic [31:0] taken_count
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  ifid_t       ifid_q;
  logic        fire, resolve;

  assign imem_req  = !reset && !id_stall;
  assign imem_addr = pc_q;
  assign fire      = imem_req && imem_ready;

  // Resolution is only honoured in RUN; a branch sitting in the delay slot while PEND is dropped.
  assign resolve = (state_q == RUN) && id_valid && !id_stall &&
                   (id_is_jump || (id_is_branch && action));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    case (state_q)
      RUN: begin
        if (resolve && fire) begin
          pc_d = id_target;
        end else if (resolve) begin
          tgt_d   = id_target;
          state_d = PEND;
        end else if (fire) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      PEND: begin
        if (fire) begin
          pc_d    = tgt_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      ifid_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      ifid_q.vld <= fire;
      if (fire) begin
        ifid_q.pc    <= pc_q;
        ifid_q.instr <= imem_rdata;
      end
    end
  end

  assign if_valid         = ifid_q.vld;
  assign if_pc            = ifid_q.pc;
  assign if_instr         = ifid_q.instr;
  assign redirect_pending = (state_q == PEND);

`ifdef BRANCH_STATS_EN
  logic        elig;
  logic [31:0] bcnt_q, tcnt_q;

  assign elig = (state_q == RUN) && id_valid && !id_stall && (id_is_branch || id_is_jump);

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      if (elig)    bcnt_q <= bcnt_q + 32'd1;
      if (resolve) tcnt_q <= tcnt_q + 32'd1;
    end
  end

  assign branch_count = bcnt_q;
  assign taken_count  = tcnt_q;
`else
  assign branch_count = '0;
  assign taken_count  = '0;
`endif

endmodule

// File: tb/tb_branch_fetch_ctrl.sv
// Scoreboard bench for branch_fetch_ctrl: stimulus pushes expected IF/ID deliveries, a negedge monitor pops and compares.
module tb_branch_fetch_ctrl;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0, id_is_branch = 1'b0, id_is_jump = 1'b0, action = 1'b0;
  logic [31:0] id_target = '0;
  logic        id_stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        redirect_pending;
  logic [31:0] branch_count, taken_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Memory model: each word is its address scrambled with a fixed key.
  assign imem_rdata = imem_addr ^ KEY;

  branch_fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_is_jump(id_is_jump),
    .action(action), .id_target(id_target), .id_stall(id_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .redirect_pending(redirect_pending),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every delivery must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && if_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deliver_unexpected: got pc %h with empty scoreboard", if_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("deliver_pc", if_pc, e.pc);
        chk("deliver_instr", if_instr, e.instr);
      end
    end
  end

  // One cycle: drive ID/imem inputs, check fetch-side outputs at negedge, push expected delivery on fire.
  task automatic cyc(input logic rdy, input logic vld, input logic br, input logic jmp,
                     input logic act, input logic stl, input logic [31:0] tgt,
                     input logic [31:0] exp_addr, input logic exp_pend);
    imem_ready   = rdy;
    id_valid     = vld;
    id_is_branch = br;
    id_is_jump   = jmp;
    action       = act;
    id_stall     = stl;
    id_target    = tgt;
    @(negedge clk);
    chk("imem_req", {31'd0, imem_req}, {31'd0, !stl});
    chk("imem_addr", imem_addr, exp_addr);
    chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, exp_pend});
    if (!stl && rdy) sb.push_back('{pc: exp_addr, instr: exp_addr ^ KEY});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input logic [31:0] b, input logic [31:0] t);
    logic [31:0] eb, et;
`ifdef BRANCH_STATS_EN
    eb = b;
    et = t;
`else
    eb = 32'd0;
    et = 32'd0;
`endif
    chk("branch_count", branch_count, eb);
    chk("taken_count", taken_count, et);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0000_3000);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pending", {31'd0, redirect_pending}, 32'd0);
    chk_cnt(0, 0);
    reset = 1'b0;

    // rdy vld br jmp act stl target           addr          pend
    cyc(1, 0, 0, 0, 0, 0, 32'h0,           32'h0000_3000, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,           32'h0000_3004, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,           32'h0000_3008, 0);
    // taken branch, delay slot fetch completes same cycle
    cyc(1, 1, 1, 0, 1, 0, 32'h0000_3100,   32'h0000_300C, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,           32'h0000_3100, 0);
    // taken branch while memory not ready -> PEND
    cyc(0, 1, 1, 0, 1, 0, 32'h0000_3200,   32'h0000_3104, 0);
    // branch in delay slot while PEND: ignored and not counted
    cyc(0, 1, 1, 0, 1, 0, 32'h0000_3999,   32'h0000_3104, 1);
    cyc(1, 1, 1, 0, 1, 0, 32'h0000_3999,   32'h0000_3104, 1);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,           32'h0000_3200, 0);
    // not-taken branch
    cyc(1, 1, 1, 0, 0, 0, 32'h0000_3500,   32'h0000_3204, 0);
    chk_cnt(3, 2);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,           32'h0000_3208, 0);
    // jump held by stall, then accepted
    cyc(1, 1, 0, 1, 0, 1, 32'h0000_3300,   32'h0000_320C, 0);
    cyc(1, 1, 0, 1, 0, 1, 32'h0000_3300,   32'h0000_320C, 0);
    cyc(1, 1, 0, 1, 0, 0, 32'h0000_3300,   32'h0000_320C, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,           32'h0000_3300, 0);
    // enter PEND, then reset drops the latched target
    cyc(0, 1, 1, 0, 1, 0, 32'h0000_3400,   32'h0000_3304, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0,           32'h0000_3304, 1);
    chk_cnt(5, 4);
    reset = 1'b1;
    imem_ready = 1'b1;
    @(negedge clk);
    chk("rst_pend_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_cnt(0, 0);
    // jump to the top word: delay slot 0x3000, then 0xFFFFFFFC wraps to 0
    cyc(1, 1, 0, 1, 0, 0, 32'hFFFF_FFFC,   32'h0000_3000, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,           32'hFFFF_FFFC, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0,           32'h0000_0000, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0,           32'h0000_0004, 0);
    chk_cnt(1, 1);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
